// File: rtl/serial_twos_complementer.sv
// Serial two's complementer: shifts an operand out LSB first, inverting every
// bit above the first 1, and assembles the parallel result alongside.
//
// state | meaning
// IDLE  | waiting for start; result holds the last conversion
// SHIFT | one operand bit converted per edge, WIDTH edges in total
// DONE  | single cycle that raises the done pulse
module serial_twos_complementer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             serial_out,
    output logic             serial_valid,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             seen_one;
    logic             cnt_last;
    logic             bit_out;

    assign cnt_last = (cnt == LAST);
    // Bits up to and including the first 1 pass through; later bits invert.
    assign bit_out  = sr[0] ^ seen_one;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr           <= '0;
            cnt          <= '0;
            seen_one     <= 1'b0;
            result       <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_valid <= 1'b0;
                    done         <= 1'b0;
                    if (start) begin
                        sr       <= data_in;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                    end
                end
                SHIFT: begin
                    serial_out   <= bit_out;
                    serial_valid <= 1'b1;
                    result       <= {bit_out, result[WIDTH-1:1]};
                    seen_one     <= seen_one | sr[0];
                    sr           <= sr >> 1;
                    // Wrap to zero on the last bit so the count never passes WIDTH-1.
                    cnt          <= cnt_last ? '0 : cnt + CW'(1);
                end
                DONE: begin
                    done         <= 1'b1;
                    serial_valid <= 1'b0;
                end
                default: begin
                    serial_valid <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Bench for serial_twos_complementer: vector table, hand-written timing
// sequences and a random sweep, all scored against a queue of expected results.
module tb_serial_twos_complementer;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic         start   = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         busy;
    logic         serial_out;
    logic         serial_valid;
    logic [W-1:0] result;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_bits  = '0;
    int           mon_nbits = 0;
    logic         prev_done = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    serial_twos_complementer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_in      (data_in),
        .busy         (busy),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .result       (result),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic convert(input logic [W-1:0] d, input logic [W-1:0] e);
        wait_idle();
        start   = 1'b1;
        data_in = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = W'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 20);
        check("done_seen", done, 1'b1);
        check("done_latency", n, 9);
    endtask

    initial begin
        int busy_cycles;
        logic [W-1:0] d;

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    mon_bits  = '0;
                    mon_nbits = 0;
                end else begin
                    if (serial_valid) begin
                        mon_bits = {serial_out, mon_bits[W-1:1]};
                        mon_nbits++;
                    end
                    if (done) begin
                        check("done_expected", exp_q.size() > 0, 1'b1);
                        if (exp_q.size() > 0) begin
                            logic [W-1:0] e;
                            e = exp_q.pop_front();
                            check("result", result, e);
                            check("serial_bits", mon_bits, e);
                            check("serial_count", mon_nbits, W);
                        end
                        mon_nbits = 0;
                    end
                    if (done && prev_done) check("done_width", 2, 1);
                end
                prev_done = done;
            end
        join_none

        vecs[0] = '{8'h06, 8'hFA};
        vecs[1] = '{8'h01, 8'hFF};
        vecs[2] = '{8'h00, 8'h00};
        vecs[3] = '{8'h80, 8'h80};
        vecs[4] = '{8'hFF, 8'h01};
        vecs[5] = '{8'h7F, 8'h81};

        // Reset asserted with no clock edge yet.
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", serial_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_serial", serial_out, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].data, vecs[i].exp);
            wait_done();
        end

        // Exact timing of 8'h06 with a start re-pulse mid-shift that must be ignored.
        wait_idle();
        start   = 1'b1;
        data_in = 8'h06;
        exp_q.push_back(8'hFA);
        @(posedge clk);
        #1;
        start   = 1'b0;
        check("lat_busy0", busy, 1'b1);
        check("lat_valid0", serial_valid, 1'b0);
        busy_cycles = 1;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 3 || k == 4);
            if (start) data_in = 8'h55;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("lat_valid", serial_valid, (k <= 8) ? 1'b1 : 1'b0);
            check("lat_done", done, (k == 9) ? 1'b1 : 1'b0);
            if (busy) busy_cycles++;
        end
        check("busy_cycles", busy_cycles, 9);

        // start held high: a new conversion every 10 cycles.
        wait_idle();
        start   = 1'b1;
        data_in = 8'h03;
        repeat (3) exp_q.push_back(8'hFD);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            check("b2b_done", done, (k % 10 == 9) ? 1'b1 : 1'b0);
        end
        start = 1'b0;

        // Asynchronous reset after 4 shift edges aborts the conversion.
        wait_idle();
        start   = 1'b1;
        data_in = 8'h06;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_valid", serial_valid, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_result", result, 8'h00);
        check("arst_serial", serial_out, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("arst_no_done", done, 1'b0);
        end
        convert(8'h06, 8'hFA);
        wait_done();

        for (int t = 0; t < 200; t++) begin
            d = W'($urandom);
            convert(d, ~d + 8'd1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_twos_complementer.md
SERIAL_TWOS_COMPLEMENTER -- requirements
Module: serial_twos_complementer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to convert data_in; sampled only in IDLE.
REQ-005 data_in  input  WIDTH  operand, captured on the accepting start edge.
REQ-006 busy  output  1  high while state is not IDLE; decoded from the state register.
REQ-007 serial_out  output  1  registered two's-complement bit stream, LSB first.
REQ-008 serial_valid  output  1  registered; high while serial_out carries a valid bit.
REQ-009 result  output  WIDTH  registered parallel two's complement of the captured operand.
REQ-010 done  output  1  registered; one-cycle pulse when result is final.

Function
REQ-011 The block SHALL implement an FSM with exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1, edge SHALL load shift register <= data_in, bit counter <= 0, seen_one flag <= 0, state <= SHIFT.
REQ-013 In IDLE with start=0, state and all registers SHALL hold; serial_valid and done SHALL be 0.
REQ-014 Each SHIFT edge SHALL compute b = sr[0] and o = b XOR seen_one.
REQ-015 On that edge, serial_out <= o and serial_valid <= 1.
REQ-016 On that edge, result <= {o, result[WIDTH-1:1]}, seen_one <= seen_one OR b, sr <= sr >> 1, counter <= counter + 1.
REQ-017 When counter == WIDTH-1 on a SHIFT edge, state SHALL move to DONE; otherwise it SHALL stay in SHIFT. SHIFT therefore lasts exactly WIDTH edges.
REQ-018 The DONE edge SHALL set done <= 1, serial_valid <= 0 and state <= IDLE; done SHALL clear on the following edge.
REQ-019 Latency from the accepting start edge (edge 0):
  - serial_valid high after edges 1..WIDTH;
  - result final after edge WIDTH;
  - done high for exactly the cycle after edge WIDTH+1.
REQ-020 result SHALL hold its value from edge WIDTH until the next accepted start has shifted new bits in.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored without queuing.
REQ-022 A start held high through DONE SHALL be accepted on the first IDLE edge, giving one idle cycle between back-to-back conversions.
REQ-023 data_in changes after the accepting edge SHALL NOT affect the conversion in progress.
REQ-024 Operand 0 SHALL yield result 0.
REQ-025 Operand 2^(WIDTH-1) SHALL yield itself (wrap-around, no overflow flag).
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force:
  - state=IDLE;
  - sr, counter, seen_one, result = 0;
  - serial_out, serial_valid, done = 0, busy=0.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no done pulse; the partial result SHALL be cleared.
REQ-029 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 WIDTH=8, data_in=8'h06, start pulse -> serial_out over 8 valid cycles 0,1,0,1,1,1,1,1; result=8'hFA; done pulse one cycle after the last valid bit.
REQ-031 data_in=8'h01 -> result 8'hFF. data_in=8'h00 -> result 8'h00 with all serial bits 0. data_in=8'h80 -> result 8'h80.
REQ-032 start re-pulsed with data_in=8'h55 during SHIFT of 8'h06 -> ignored; result=8'hFA; busy stays high for exactly 9 cycles (8 SHIFT + DONE).
REQ-033 start held high continuously with data_in=8'h03 -> conversions repeat every 10 cycles, each giving result 8'hFD with one done pulse per conversion.
REQ-034 rst_n pulsed low asynchronously mid-cycle after 4 SHIFT edges -> outputs clear before the next clock edge; no done pulse; a fresh start with 8'h06 then yields 8'hFA.
REQ-035 Randomized WIDTH=8 operands, 200 trials -> result == (~data_in + 1) mod 256 and serial bits match result LSB first.
